// File: rtl/cb_dina_map.sv
// CB port-A write mapper: two-stage pipeline that steers RSA (C) or temp-bank (TB) rows onto CB lanes.
// Optional macro CB_DINA_HOLD_EN: lanes not written hold their previous CB_dina instead of zero.
module cb_dina_map #(
    parameter int X              = 4,
    parameter int L              = 4,
    parameter int RSA_DW         = 32,
    parameter int SEQ_CNT_DW     = 5,
    parameter int CB_DINA_SEL_DW = 5
) (
    input  logic                       clk,
    input  logic                       sys_rst_n,
    input  logic [CB_DINA_SEL_DW-1:0]  CB_dina_sel,
    input  logic                       l_k_0,
    input  logic [SEQ_CNT_DW-1:0]      seq_cnt_in,
    input  logic signed [X*RSA_DW-1:0] C_CB_dina,
    input  logic signed [L*RSA_DW-1:0] TB_CB_dina,
    output logic signed [L*RSA_DW-1:0] CB_dina,
    output logic [L-1:0]               CB_wea,
    output logic                       CB_dina_vld,
    output logic [7:0]                 wr_cnt,
    output logic                       burst_done
);

    typedef enum logic [1:0] {SRC_IDLE, SRC_C, SRC_TB} src_e;
    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_POS  = 2'b01,
        DIR_NEG  = 2'b10,
        DIR_NEW  = 2'b11
    } dir_e;
    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_FLUSH} state_e;
    typedef logic [L-1:0][RSA_DW-1:0] row_t;

    // ---------------------------------------------------------------
    // Input decode and source row selection
    // ---------------------------------------------------------------
    src_e in_src;
    dir_e in_dir;
    row_t c_row;
    row_t tb_row;
    row_t in_row;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        in_src = SRC_IDLE;
        case (CB_dina_sel[4:2])
            3'b001:  in_src = SRC_C;
            3'b100:  in_src = SRC_TB;
            default: in_src = SRC_IDLE;
        endcase
        in_dir = dir_e'(CB_dina_sel[1:0]);
    end

    for (genvar gi = 0; gi < L; gi++) begin : g_c_lane
        if (gi < X) begin : g_src
            assign c_row[gi] = C_CB_dina[gi*RSA_DW +: RSA_DW];
        end else begin : g_pad
            assign c_row[gi] = '0;
        end
    end

    assign tb_row = TB_CB_dina;

    always_comb begin
        in_row = '0;
        if (in_src == SRC_C) begin
            in_row = c_row;
        end else if (in_src == SRC_TB) begin
            in_row = tb_row;
        end
    end

    // ---------------------------------------------------------------
    // Stage 1 registers
    // ---------------------------------------------------------------
    src_e                  s1_src;
    dir_e                  s1_dir;
    logic                  s1_lk0;
    logic [SEQ_CNT_DW-1:0] s1_seq;
    row_t                  s1_row;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_src <= SRC_IDLE;
            s1_dir <= DIR_IDLE;
            s1_lk0 <= 1'b0;
            s1_seq <= '0;
            s1_row <= '0;
        end else begin
            s1_src <= in_src;
            s1_dir <= in_dir;
            s1_lk0 <= l_k_0;
            s1_seq <= seq_cnt_in;
            s1_row <= in_row;
        end
    end

    // ---------------------------------------------------------------
    // Lane mapping (NEW decode assumes the 4-lane CB arrangement)
    // ---------------------------------------------------------------
    row_t              map_row;
    logic [L-1:0]      map_wea;
    logic [RSA_DW-1:0] hi_val;
    logic [RSA_DW-1:0] lo_val;
    logic              hi_we;
    logic              lo_we;

    always_comb begin
        map_row = '0;
        map_wea = '0;
        hi_val  = '0;
        lo_val  = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        if (s1_src != SRC_IDLE) begin
            case (s1_dir)
                DIR_POS: begin
                    map_row = s1_row;
                    map_wea = '1;
                end
                DIR_NEG: begin
                    for (int i = 0; i < L; i++) begin
                        map_row[i] = s1_row[L-1-i];
                    end
                    map_wea = '1;
                end
                DIR_NEW: begin
                    if (s1_src == SRC_TB) begin
                        case (s1_seq)
                            SEQ_CNT_DW'(0): begin
                                hi_val = s1_row[3];
                                hi_we  = 1'b1;
                            end
                            SEQ_CNT_DW'(1): begin
                                lo_val = s1_row[0];
                                lo_we  = 1'b1;
                            end
                            SEQ_CNT_DW'(2): begin
                                hi_val = s1_row[0];
                                lo_val = s1_row[1];
                                hi_we  = 1'b1;
                                lo_we  = 1'b1;
                            end
                            SEQ_CNT_DW'(3): begin
                                hi_val = s1_row[1];
                                lo_val = s1_row[2];
                                hi_we  = 1'b1;
                                lo_we  = 1'b1;
                            end
                            SEQ_CNT_DW'(4): begin
                                hi_val = s1_row[2];
                                lo_val = s1_row[3];
                                hi_we  = 1'b1;
                                lo_we  = 1'b1;
                            end
                            default: ;
                        endcase
                        // l_k_0 picks which lane pair receives the landmark pair
                        if (s1_lk0) begin
                            map_row[1] = hi_val;
                            map_row[0] = lo_val;
                            map_wea[1] = hi_we;
                            map_wea[0] = lo_we;
                        end else begin
                            map_row[3] = hi_val;
                            map_row[2] = lo_val;
                            map_wea[3] = hi_we;
                            map_wea[2] = lo_we;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Stage 2 registers
    // ---------------------------------------------------------------
    row_t dina_q;
    row_t dina_next;
    logic vld_next;

`ifdef CB_DINA_HOLD_EN
    always_comb begin
        dina_next = dina_q;
        for (int i = 0; i < L; i++) begin
            if (map_wea[i]) begin
                dina_next[i] = map_row[i];
            end
        end
    end
`else
    assign dina_next = map_row;
`endif

    assign vld_next = |map_wea;

    // NOTE: datapath registers are reset too, because CB_dina must read zero immediately on reset.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dina_q      <= '0;
            CB_wea      <= '0;
            CB_dina_vld <= 1'b0;
        end else begin
            dina_q      <= dina_next;
            CB_wea      <= map_wea;
            CB_dina_vld <= vld_next;
        end
    end

    assign CB_dina = dina_q;

    // ---------------------------------------------------------------
    // Burst tracking FSM and write counter
    // ---------------------------------------------------------------
    state_e     state_q;
    state_e     state_d;
    logic       done_set;
    logic [7:0] wr_cnt_d;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            burst_done <= 1'b0;
            wr_cnt     <= '0;
        end else begin
            state_q    <= state_d;
            burst_done <= done_set;
            wr_cnt     <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (CB_wea != '0) state_d = ST_STREAM;
            ST_STREAM: if (s1_src == SRC_IDLE) state_d = ST_FLUSH;
            ST_FLUSH:  state_d = (CB_wea != '0) ? ST_STREAM : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done_set = (state_q == ST_FLUSH) && (CB_wea == '0);
    end

    // The count stays visible during the burst_done cycle; a burst that restarts there counts from 1.
    always_comb begin
        wr_cnt_d = wr_cnt;
        if (done_set) begin
            if (vld_next) begin
                wr_cnt_d = 8'd1;
            end
        end else if (burst_done) begin
            wr_cnt_d = (CB_dina_vld ? wr_cnt : 8'd0) + {7'd0, vld_next};
        end else if (vld_next && (wr_cnt != 8'hFF)) begin
            wr_cnt_d = wr_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_cb_dina_map.sv
// Scoreboard bench for cb_dina_map (default build): stimulus pushes expected writes,
// a negedge monitor pops and compares whenever CB_dina_vld is high.
module tb_cb_dina_map;

    logic         clk;
    logic         sys_rst_n;
    logic [4:0]   CB_dina_sel;
    logic         l_k_0;
    logic [4:0]   seq_cnt_in;
    logic [127:0] C_CB_dina;
    logic [127:0] TB_CB_dina;
    logic [127:0] CB_dina;
    logic [3:0]   CB_wea;
    logic         CB_dina_vld;
    logic [7:0]   wr_cnt;
    logic         burst_done;

    cb_dina_map dut (
        .clk         (clk),
        .sys_rst_n   (sys_rst_n),
        .CB_dina_sel (CB_dina_sel),
        .l_k_0       (l_k_0),
        .seq_cnt_in  (seq_cnt_in),
        .C_CB_dina   (C_CB_dina),
        .TB_CB_dina  (TB_CB_dina),
        .CB_dina     (CB_dina),
        .CB_wea      (CB_wea),
        .CB_dina_vld (CB_dina_vld),
        .wr_cnt      (wr_cnt),
        .burst_done  (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [127:0] dina;
        logic [3:0]   wea;
        bit           chk_cnt;
        logic [7:0]   cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] row4(input logic [31:0] l3, input logic [31:0] l2,
                                          input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic drive(input logic [4:0] sel, input logic lk0, input logic [4:0] seq,
                         input logic [127:0] c, input logic [127:0] t);
        @(negedge clk);
        CB_dina_sel = sel;
        l_k_0       = lk0;
        seq_cnt_in  = seq;
        C_CB_dina   = c;
        TB_CB_dina  = t;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(5'b00000, 1'b0, 5'd0, '0, '0);
    endtask

    task automatic push(input string tag, input logic [127:0] d, input logic [3:0] w,
                        input bit cc, input logic [7:0] cnt);
        exp_t e;
        e.tag = tag; e.dina = d; e.wea = w; e.chk_cnt = cc; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Monitor: every valid write must match the oldest expectation.
    always @(negedge clk) begin
        if (sys_rst_n && CB_dina_vld) begin
            if (sb.size() == 0) begin
                check("unexpected_vld", {124'd0, CB_wea}, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_dina"}, CB_dina, e.dina);
                check({e.tag, "_wea"}, {124'd0, CB_wea}, {124'd0, e.wea});
                if (e.chk_cnt) check({e.tag, "_cnt"}, {120'd0, wr_cnt}, {120'd0, e.cnt});
            end
        end
    end

    always @(negedge clk) begin
        if (burst_done) done_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] va, vb, vc, vd;
    logic [31:0] new_hi [5];
    logic [31:0] new_lo [5];
    logic [1:0]  new_we [5];
    logic [4:0]  idle_vec [4];

    initial begin
        int   d0;
        bit   seen;
        logic [127:0] tb_new;

        va = 32'h0000_0011; vb = 32'h0000_0022; vc = 32'h0000_0033; vd = 32'hFFFF_FFFB;
        // NEW decode table (hi lane, lo lane, {hi_we, lo_we}) for seq 0..4
        new_hi[0] = vd;    new_lo[0] = 32'd0; new_we[0] = 2'b10;
        new_hi[1] = 32'd0; new_lo[1] = va;    new_we[1] = 2'b01;
        new_hi[2] = va;    new_lo[2] = vb;    new_we[2] = 2'b11;
        new_hi[3] = vb;    new_lo[3] = vc;    new_we[3] = 2'b11;
        new_hi[4] = vc;    new_lo[4] = vd;    new_we[4] = 2'b11;
        idle_vec[0] = 5'b01001; idle_vec[1] = 5'b00111;
        idle_vec[2] = 5'b10000; idle_vec[3] = 5'b11101;
        tb_new = row4(vd, vc, vb, va);

        sys_rst_n = 1'b0;
        CB_dina_sel = '0; l_k_0 = 1'b0; seq_cnt_in = '0; C_CB_dina = '0; TB_CB_dina = '0;
        repeat (2) @(negedge clk);
        check("rst_dina", CB_dina, 128'd0);
        check("rst_wea", {124'd0, CB_wea}, 128'd0);
        check("rst_vld", {127'd0, CB_dina_vld}, 128'd0);
        check("rst_cnt", {120'd0, wr_cnt}, 128'd0);
        check("rst_done", {127'd0, burst_done}, 128'd0);
        sys_rst_n = 1'b1;
        idle(2);

        // POS and NEG single writes
        drive(5'b00101, 1'b0, 5'd0, row4(40, 30, 20, 10), row4(9, 9, 9, 9));
        push("pos", row4(40, 30, 20, 10), 4'b1111, 1'b1, 8'd1);
        idle(8);
        drive(5'b00110, 1'b0, 5'd0, row4(40, 30, 20, 10), row4(9, 9, 9, 9));
        push("neg", row4(10, 20, 30, 40), 4'b1111, 1'b1, 8'd1);
        idle(8);

        // Selects that decode to IDLE produce no write
        for (int i = 0; i < 4; i++) begin
            drive(idle_vec[i], 1'b1, 5'd2, row4(1, 2, 3, 4), row4(5, 6, 7, 8));
            idle(2);
            check($sformatf("idle_vec%0d_wea", i), {124'd0, CB_wea}, 128'd0);
            check($sformatf("idle_vec%0d_dina", i), CB_dina, 128'd0);
        end
        idle(4);

        // NEW decode on both lane pairs; seq 5 must not write
        for (int lk = 0; lk < 2; lk++) begin
            for (int s = 0; s < 6; s++) begin
                drive(5'b10011, lk[0], s[4:0], row4(7, 7, 7, 7), tb_new);
                if (s < 5) begin
                    if (lk == 1)
                        push($sformatf("new1_s%0d", s), row4(0, 0, new_hi[s], new_lo[s]),
                             {2'b00, new_we[s]}, 1'b1, 8'(s + 1));
                    else
                        push($sformatf("new0_s%0d", s), row4(new_hi[s], new_lo[s], 0, 0),
                             {new_we[s], 2'b00}, 1'b1, 8'(s + 1));
                end
            end
            idle(8);
        end

        // Six-cycle POS burst, then the burst_done pulse and counter clear
        d0 = done_seen;
        for (int i = 0; i < 6; i++) begin
            drive(5'b00101, 1'b0, 5'd0, row4(i + 4, i + 3, i + 2, i + 1), '0);
            push($sformatf("burst%0d", i), row4(i + 4, i + 3, i + 2, i + 1), 4'b1111, 1'b1, 8'(i + 1));
        end
        idle(1);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (burst_done) seen = 1'b1;
        end
        check("burst_done_seen", {127'd0, seen}, 128'd1);
        if (seen) begin
            check("burst_cnt_at_done", {120'd0, wr_cnt}, 128'd6);
            @(negedge clk);
            check("burst_cnt_cleared", {120'd0, wr_cnt}, 128'd0);
        end
        idle(10);
        check("burst_done_once", done_seen - d0, 128'd1);

        // Reset in cycle 3 of a six-cycle burst
        d0 = done_seen;
        for (int i = 0; i < 4; i++) begin
            drive(5'b00101, 1'b0, 5'd0, row4(50, 60, 70, 80 + i), '0);
            if (i < 2) push($sformatf("rstb%0d", i), row4(50, 60, 70, 80 + i), 4'b1111, 1'b1, 8'(i + 1));
        end
        #2 sys_rst_n = 1'b0;
        CB_dina_sel = '0;
        #1;
        check("midrst_dina", CB_dina, 128'd0);
        check("midrst_wea", {124'd0, CB_wea}, 128'd0);
        check("midrst_vld", {127'd0, CB_dina_vld}, 128'd0);
        check("midrst_cnt", {120'd0, wr_cnt}, 128'd0);
        check("midrst_done", {127'd0, burst_done}, 128'd0);
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;
        idle(15);
        check("midrst_no_done", done_seen - d0, 128'd0);

        // First write after reset appears exactly two cycles after its input
        drive(5'b00101, 1'b0, 5'd0, row4(4, 3, 2, 1), '0);
        push("post_rst", row4(4, 3, 2, 1), 4'b1111, 1'b1, 8'd1);
        idle(1);
        check("lat_cycle1_vld", {127'd0, CB_dina_vld}, 128'd0);
        idle(1);
        check("lat_cycle2_vld", {127'd0, CB_dina_vld}, 128'd1);
        idle(8);

        check("sb_drained", sb.size(), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cb_dina_map.md
CB_DINA_MAP -- requirements
Module: cb_dina_map

Interface
REQ-001 Parameters SHALL be: X, default 4, RSA row lanes; L, default 4, CB bank lanes; RSA_DW, default 32, lane width; SEQ_CNT_DW, default 5, sequence counter width; CB_DINA_SEL_DW, default 5, select width.
REQ-002 Ports SHALL be as follows, one per line, clock and reset first:
- clk  in  1  single clock; all logic on its rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- CB_dina_sel  in  CB_DINA_SEL_DW  [4:2] source: 000 IDLE, 001 C, 100 TB, others IDLE; [1:0] direction: 00 IDLE, 01 POS, 10 NEG, 11 NEW.
- l_k_0  in  1  landmark index LSB; 1 selects lanes 0/1, 0 selects lanes 2/3 in NEW.
- seq_cnt_in  in  SEQ_CNT_DW  write-step index, aligned with CB_dina_sel.
- C_CB_dina  in  X*RSA_DW  signed RSA result row.
- TB_CB_dina  in  L*RSA_DW  signed temp-bank read row.
- CB_dina  out  L*RSA_DW  signed CB port-A write data.
- CB_wea  out  L  per-lane write enable.
- CB_dina_vld  out  1  high when any CB_wea bit is high.
- wr_cnt  out  8  count of valid write cycles in the current burst.
- burst_done  out  1  one-cycle pulse at end of burst.

Function
REQ-003 Stage 1 SHALL register the select, l_k_0, seq_cnt_in and the chosen source row (C or TB).
REQ-004 Stage 2 SHALL register the lane-mapped CB_dina and CB_wea; latency from inputs to outputs SHALL be exactly 2 cycles, with no stalls.
REQ-005 POS SHALL map lane i to lane i and assert CB_wea=4'b1111.
REQ-006 NEG SHALL map source lane L-1-i to lane i and assert CB_wea=4'b1111.
REQ-007 In NEW, lo/hi SHALL be lanes 0/1 when l_k_0=1 and lanes 2/3 when l_k_0=0.
REQ-008 NEW SHALL decode the stage-1 seq as follows:
- seq 0: hi<=src[3], wea hi only.
- seq 1: lo<=src[0], wea lo only.
- seq 2: hi<=src[0], lo<=src[1].
- seq 3: hi<=src[1], lo<=src[2].
- seq 4: hi<=src[2], lo<=src[3].
- seq 5 or above: no write.
REQ-009 In NEW, lanes not written SHALL carry 0.
REQ-010 IDLE source or IDLE direction SHALL give CB_wea=0 and CB_dina=0.
REQ-011 Source C with NEW SHALL be treated as IDLE.
REQ-012 Each cycle SHALL be decoded independently; a select change takes effect on its own data 2 cycles later, with no blending of cycles.
REQ-013 The burst FSM SHALL use states IDLE, STREAM and FLUSH.
REQ-014 IDLE SHALL go to STREAM on the first cycle the stage-2 wea is nonzero.
REQ-015 STREAM SHALL go to FLUSH on the first cycle the stage-1 source is IDLE.
REQ-016 In FLUSH, a nonzero wea SHALL return the FSM to STREAM; otherwise, after 1 cycle, it SHALL pulse burst_done and return to IDLE.
REQ-017 wr_cnt SHALL increment on each CB_dina_vld cycle, saturate at 255, and clear on the cycle after burst_done.
REQ-018 If a new burst starts on the burst_done cycle, it SHALL count from 1.

Reset
REQ-019 Asserting sys_rst_n low SHALL immediately clear, asynchronously:
- all pipeline registers
- CB_dina, CB_wea, CB_dina_vld, wr_cnt and burst_done to 0
- the FSM to IDLE
REQ-020 Reset mid-burst SHALL abort the burst with no burst_done pulse.
REQ-021 The first valid output after reset release SHALL appear 2 cycles after the first non-IDLE input.

Configuration
REQ-022 With macro CB_DINA_HOLD_EN defined, lanes with CB_wea=0 SHALL hold their previous CB_dina value instead of driving 0.
REQ-023 Without CB_DINA_HOLD_EN, REQ-009 and REQ-010 zeroing SHALL apply.
REQ-024 Reset behaviour SHALL be identical with and without CB_DINA_HOLD_EN.

Verification
REQ-025 Bench SHALL cover POS: sel=5'b00101 with C lanes {3,2,1,0}={40,30,20,10} -> 2 cycles later CB_dina={40,30,20,10}, CB_wea=1111, wr_cnt=1.
REQ-026 Bench SHALL cover NEG: sel=5'b00110 with the same data -> CB_dina={10,20,30,40}, CB_wea=1111.
REQ-027 Bench SHALL cover NEW with l_k_0=0: sel=5'b10011, TB lanes {3,2,1,0}={D,C,B,A}, seq 0..5 -> wea 1000,0100,1100,1100,1100,0000 and lane3/lane2 = D/0, 0/A, A/B, B/C, C/D.
REQ-028 Bench SHALL cover NEW with l_k_0=1: same stimulus -> the same pattern on lanes 1/0, with lanes 3/2 equal to 0.
REQ-029 Bench SHALL cover a burst: 6 POS cycles then IDLE -> wr_cnt reaches 6, burst_done pulses once, and wr_cnt reads 0 the following cycle.
REQ-030 Bench SHALL cover reset mid-burst: sys_rst_n low at cycle 3 of a 6-cycle burst -> outputs 0 immediately and no burst_done.
